alu_arbiter: RTL and testbench
==============================

Name: alu_arbiter

Overview:
- Shares one 32-bit ALU between two requesters: 0 = main datapath, 1 = auxiliary unit (multi-cycle/branch helper).
- Round-robin arbitration; valid/ready request handshake on each side.
- One registered response stage with backpressure, tagged with requester id.
- Instantiates the existing ALU (ports con, op1, op2, sft_amt, result) internally.

Parameters:
- PRIO_INIT, 0: requester that wins the first contended cycle after reset (0 or 1).
- CNT_W, 16: width of the statistics counters (used only with the optional feature).

Ports:
- clk  in  1  clock, all state on rising edge.
- reset  in  1  synchronous, active-high reset.
- req0_valid  in  1  requester 0 has an operation.
- req0_ready  out  1  requester 0 operation accepted this cycle.
- req0_con  in  3  ALU op: 0 add, 1 sub, 2 and, 3 or, 4 sll, 5 srl.
- req0_op1 / req0_op2  in  32  operands.
- req0_sft_amt  in  5  shift amount.
- req1_valid, req1_ready, req1_con, req1_op1, req1_op2, req1_sft_amt: same as requester 0.
- rsp_valid  out  1  response held in output register.
- rsp_ready  in  1  consumer takes response.
- rsp_id  out  1  requester that issued the response.
- rsp_result  out  32  ALU result.
- rsp_err  out  1  con was 6 or 7 (unsupported).

Behaviour:
- Reset (sync, high): rsp_valid=0, rsp_result=0, rsp_id=0, rsp_err=0, rr_ptr=PRIO_INIT. Any held response is dropped. req0_ready=req1_ready=0 while reset is high.
- Accept condition: can_accept = !reset && (!rsp_valid || rsp_ready).
- Arbitration (combinational):
  - Only one requester valid: it is granted.
  - Both valid: rr_ptr is granted.
  - reqN_ready = can_accept && granted(N).
- rr_ptr updates only on an accepted transfer; it then points to the non-granted requester. Under contention this guarantees alternation: a waiting requester is served after at most one transfer by the other. No change on idle or stalled cycles.
- Datapath: grant mux drives the ALU inputs. On acceptance, the output register loads:
  - rsp_result = ALU result, or 0 when con>5.
  - rsp_id = granted index.
  - rsp_err = (con>5).
  - rsp_valid = 1.
- Latency: exactly 1 cycle from accept to rsp_valid. Throughput: 1 operation/cycle while rsp_ready=1.
- Stall: rsp_valid=1 && rsp_ready=0 -> both readies 0; output register, rr_ptr and counters hold.
- Simultaneous drain and accept (rsp_valid=1, rsp_ready=1, new grant): register reloads in the same cycle; no bubble.
- Drain only (rsp_ready=1, no request): rsp_valid->0; other output fields hold their last values.
- Arithmetic: 32-bit wrap-around for add/sub, no flags. Shifts are logical by sft_amt (0..31).
- Protocol:
  - Requesters must hold valid and operands stable until ready.
  - Valid must not depend on ready.
  - The consumer's rsp_ready may depend on rsp_valid.

Optional Feature:
- Macro ALU_ARB_STATS_EN.
- Defined: adds outputs grant_cnt0, grant_cnt1 and contend_cnt (CNT_W each).
  - grant_cntN increments on each accepted transfer from requester N.
  - contend_cnt increments on each cycle where both valids are high and can_accept=1.
  - All three saturate at all-ones and clear on reset.
- Not defined: these ports and registers do not exist; all other behaviour is identical.

Decomposition:
- Shared package alu_arb_pkg holds:
  - ALU op constants: OP_ADD=0, OP_SUB=1, OP_AND=2, OP_OR=3, OP_SLL=4, OP_SRL=5, OP_MAX=5.
  - Requester id constants REQ_MAIN=0, REQ_AUX=1.
- One natural sub-module: rr_arb2, a 2-way round-robin grant with pointer update on accept.
- The ALU is reused unchanged as a second instance.

Test Plan:
- Requester 0 only; op1=55, op2=33; con=0,1,2,3 on consecutive cycles; rsp_ready=1 -> rsp_result 88, 22, 33, 55 one cycle after each accept; rsp_id=0; rsp_err=0.
- Requester 1 only; op1=55, sft_amt=2; con=4 then 5 -> rsp_result 220 then 13; rsp_id=1.
- Both valid for 4 cycles, PRIO_INIT=0 -> grants 0,1,0,1; rsp_id sequence 0,1,0,1; no bubbles.
- Hold rsp_ready=0 for 3 cycles with both valid -> readies 0; rsp_result/rsp_id frozen; rr_ptr unchanged. Release -> next grant continues alternation.
- con=7, op1=55 -> rsp_result=0, rsp_err=1. Next op con=0 -> rsp_err=0.
- Assert reset with rsp_valid=1 mid-stream -> next cycle rsp_valid=0 and readies 0. After release, first contended grant goes to PRIO_INIT. With ALU_ARB_STATS_EN, all counters read 0.

Source files
------------

// File: rtl/alu_arb_pkg.sv
// alu_arb_pkg: shared ALU opcode and requester id constants
package alu_arb_pkg;
  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_SLL = 3'd4;
  localparam logic [2:0] OP_SRL = 3'd5;
  localparam logic [2:0] OP_MAX = 3'd5;
  localparam logic REQ_MAIN = 1'b0;
  localparam logic REQ_AUX  = 1'b1;
endpackage

// File: rtl/alu.sv
// alu: combinational 32-bit ALU (add, sub, and, or, logical shifts)
module alu
  import alu_arb_pkg::*;
(
  input  logic [2:0]  con,
  input  logic [31:0] op1,
  input  logic [31:0] op2,
  input  logic [4:0]  sft_amt,
  output logic [31:0] result
);
  always_comb
    result = con == OP_ADD ? op1 + op2 :
             con == OP_SUB ? op1 - op2 :
             con == OP_AND ? op1 & op2 :
             con == OP_OR  ? op1 | op2 :
             con == OP_SLL ? op1 << sft_amt :
             con == OP_SRL ? op1 >> sft_amt : '0;
endmodule

// File: rtl/alu_arbiter_rr_arb2.sv
// rr_arb2: two-way round-robin grant, pointer moves to the loser on each accepted transfer
module rr_arb2
  import alu_arb_pkg::*;
#(
  parameter logic PRIO_INIT = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] valid,
  input  logic       accept,
  output logic       gnt,
  output logic       any
);
  logic ptr;
  assign any = |valid;
  assign gnt = &valid ? ptr : valid[REQ_AUX];
  always_ff @(posedge clk)
    if (reset) ptr <= PRIO_INIT;
    else if (accept && any) ptr <= ~gnt;
endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: two requesters share one ALU with a registered tagged response; ALU_ARB_STATS_EN adds grant/contention counters
module alu_arbiter
  import alu_arb_pkg::*;
#(
  parameter int PRIO_INIT = 0,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [2:0]       req0_con,
  input  logic [31:0]      req0_op1,
  input  logic [31:0]      req0_op2,
  input  logic [4:0]       req0_sft_amt,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [2:0]       req1_con,
  input  logic [31:0]      req1_op1,
  input  logic [31:0]      req1_op2,
  input  logic [4:0]       req1_sft_amt,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [31:0]      rsp_result,
  output logic             rsp_err
`ifdef ALU_ARB_STATS_EN
  ,
  output logic [CNT_W-1:0] grant_cnt0,
  output logic [CNT_W-1:0] grant_cnt1,
  output logic [CNT_W-1:0] contend_cnt
`endif
);
  logic can_accept, gnt, any, fire, bad;
  logic [2:0] con;
  logic [31:0] op1, op2, result;
  logic [4:0] sft_amt;
  if (CNT_W < 1 || PRIO_INIT < 0 || PRIO_INIT > 1) begin : g_bad_param
    $error("alu_arbiter: invalid CNT_W or PRIO_INIT");
  end
  assign can_accept = !reset && (!rsp_valid || rsp_ready);
  assign fire = can_accept && any;
  assign req0_ready = fire && gnt == REQ_MAIN;
  assign req1_ready = fire && gnt == REQ_AUX;
  rr_arb2 #(.PRIO_INIT(1'(PRIO_INIT))) u_arb (
    .clk(clk), .reset(reset), .valid({req1_valid, req0_valid}),
    .accept(can_accept), .gnt(gnt), .any(any)
  );
  always_comb begin
    con = gnt ? req1_con : req0_con;
    op1 = gnt ? req1_op1 : req0_op1;
    op2 = gnt ? req1_op2 : req0_op2;
    sft_amt = gnt ? req1_sft_amt : req0_sft_amt;
    bad = con > OP_MAX;
  end
  alu u_alu (.con(con), .op1(op1), .op2(op2), .sft_amt(sft_amt), .result(result));
  always_ff @(posedge clk)
    if (reset) begin
      rsp_valid <= 1'b0;
      rsp_id <= 1'b0;
      rsp_result <= '0;
      rsp_err <= 1'b0;
    end else if (fire) begin
      rsp_valid <= 1'b1;
      rsp_id <= gnt;
      rsp_result <= bad ? '0 : result;
      rsp_err <= bad;
    end else if (rsp_ready) rsp_valid <= 1'b0;
`ifdef ALU_ARB_STATS_EN
  always_ff @(posedge clk)
    if (reset) begin
      grant_cnt0 <= '0;
      grant_cnt1 <= '0;
      contend_cnt <= '0;
    end else begin
      if (req0_ready && !(&grant_cnt0)) grant_cnt0 <= grant_cnt0 + 1'b1;
      if (req1_ready && !(&grant_cnt1)) grant_cnt1 <= grant_cnt1 + 1'b1;
      if (can_accept && req0_valid && req1_valid && !(&contend_cnt)) contend_cnt <= contend_cnt + 1'b1;
    end
`endif
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed plan plus randomized traffic against a transaction-level reference model
module tb_alu_arbiter;
  localparam int PRIO = 0;
  localparam int CW = 16;
  logic clk = 0, reset;
  logic req0_valid, req0_ready, req1_valid, req1_ready;
  logic [2:0] req0_con, req1_con;
  logic [31:0] req0_op1, req0_op2, req1_op1, req1_op2;
  logic [4:0] req0_sft_amt, req1_sft_amt;
  logic rsp_valid, rsp_ready, rsp_id, rsp_err;
  logic [31:0] rsp_result;
`ifdef ALU_ARB_STATS_EN
  logic [CW-1:0] grant_cnt0, grant_cnt1, contend_cnt;
  int s_g0, s_g1, s_ct;
`endif
  int n_checks = 0, n_err = 0;
  bit m_valid, m_id, m_err, m_turn, acc0, acc1;
  logic [31:0] m_res;
  alu_arbiter #(.PRIO_INIT(PRIO), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_con(req0_con),
    .req0_op1(req0_op1), .req0_op2(req0_op2), .req0_sft_amt(req0_sft_amt),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_con(req1_con),
    .req1_op1(req1_op1), .req1_op2(req1_op2), .req1_sft_amt(req1_sft_amt),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_err(rsp_err)
`ifdef ALU_ARB_STATS_EN
    , .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1), .contend_cnt(contend_cnt)
`endif
  );
  always #5 clk = ~clk;
  function automatic logic [31:0] alu_ref(input int c, input logic [31:0] a, b, input int s);
    case (c)
      0: return a + b;
      1: return a - b;
      2: return a & b;
      3: return a | b;
      4: return a << s;
      5: return a >> s;
      default: return 0;
    endcase
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  // One cycle: check readies before the edge, advance the model across it, check the response after it
  task automatic step();
    bit ca, g, fire, both;
    int c, s;
    logic [31:0] a, b;
    #1;
    both = req0_valid && req1_valid;
    ca = !reset && (!m_valid || rsp_ready);
    g = both ? m_turn : req1_valid;
    fire = ca && (req0_valid || req1_valid);
    acc0 = fire && !g;
    acc1 = fire && g;
    chk("req0_ready", 32'(req0_ready), 32'(acc0));
    chk("req1_ready", 32'(req1_ready), 32'(acc1));
    c = g ? int'(req1_con) : int'(req0_con);
    a = g ? req1_op1 : req0_op1;
    b = g ? req1_op2 : req0_op2;
    s = g ? int'(req1_sft_amt) : int'(req0_sft_amt);
    @(posedge clk);
    if (reset) begin
      m_valid = 0; m_res = 0; m_id = 0; m_err = 0; m_turn = PRIO[0];
`ifdef ALU_ARB_STATS_EN
      s_g0 = 0; s_g1 = 0; s_ct = 0;
`endif
    end else begin
      if (fire) begin
        m_valid = 1; m_id = g; m_err = c > 5; m_res = alu_ref(c, a, b, s); m_turn = !g;
      end else if (rsp_ready) m_valid = 0;
`ifdef ALU_ARB_STATS_EN
      if (acc0 && s_g0 < (1 << CW) - 1) s_g0++;
      if (acc1 && s_g1 < (1 << CW) - 1) s_g1++;
      if (both && ca && s_ct < (1 << CW) - 1) s_ct++;
`endif
    end
    #1;
    chk("rsp_valid", 32'(rsp_valid), 32'(m_valid));
    chk("rsp_id", 32'(rsp_id), 32'(m_id));
    chk("rsp_result", rsp_result, m_res);
    chk("rsp_err", 32'(rsp_err), 32'(m_err));
`ifdef ALU_ARB_STATS_EN
    chk("grant_cnt0", 32'(grant_cnt0), 32'(s_g0));
    chk("grant_cnt1", 32'(grant_cnt1), 32'(s_g1));
    chk("contend_cnt", 32'(contend_cnt), 32'(s_ct));
`endif
    @(negedge clk);
  endtask
  initial begin
    logic [31:0] exp_a [4];
    exp_a = '{88, 22, 33, 55};
    reset = 1; rsp_ready = 1;
    req0_valid = 0; req0_con = 0; req0_op1 = 55; req0_op2 = 33; req0_sft_amt = 2;
    req1_valid = 0; req1_con = 0; req1_op1 = 55; req1_op2 = 33; req1_sft_amt = 2;
    m_turn = PRIO[0];
    @(negedge clk);
    step(); step();
    reset = 0;
    req0_valid = 1;
    for (int i = 0; i < 4; i++) begin
      req0_con = 3'(i);
      step();
      chk("req0_only_result", rsp_result, exp_a[i]);
    end
    req0_valid = 0; req1_valid = 1; req1_con = 4;
    step();
    chk("sll_result", rsp_result, 220);
    chk("sll_id", 32'(rsp_id), 1);
    req1_con = 5;
    step();
    chk("srl_result", rsp_result, 13);
    reset = 1; req1_valid = 0;
    step();
    reset = 0; req0_valid = 1; req1_valid = 1; req0_con = 0; req1_con = 1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("contend_id", 32'(rsp_id), 32'(i % 2));
      chk("contend_nobubble", 32'(rsp_valid), 1);
    end
    rsp_ready = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_id", 32'(rsp_id), 1);
    end
    rsp_ready = 1;
    step();
    chk("release_id", 32'(rsp_id), 0);
    req1_valid = 0; req0_con = 7; req0_op1 = 55;
    step();
    chk("bad_result", rsp_result, 0);
    chk("bad_err", 32'(rsp_err), 1);
    req0_con = 0;
    step();
    chk("good_err", 32'(rsp_err), 0);
    req1_valid = 1; rsp_ready = 0;
    step();
    reset = 1;
    step();
    chk("reset_valid", 32'(rsp_valid), 0);
    reset = 0; rsp_ready = 1;
    step();
    chk("post_reset_id", 32'(rsp_id), 32'(PRIO));
    for (int i = 0; i < 2000; i++) begin
      if (acc0 || !req0_valid) begin
        req0_valid = $urandom_range(0, 2) != 0;
        req0_con = 3'($urandom_range(0, 7));
        req0_op1 = $urandom; req0_op2 = $urandom; req0_sft_amt = 5'($urandom);
      end
      if (acc1 || !req1_valid) begin
        req1_valid = $urandom_range(0, 2) != 0;
        req1_con = 3'($urandom_range(0, 7));
        req1_op1 = $urandom; req1_op2 = $urandom; req1_sft_amt = 5'($urandom);
      end
      rsp_ready = $urandom_range(0, 3) != 0;
      reset = $urandom_range(0, 199) == 0;
      step();
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
